// File: rtl/memshare_arr_rqst_tracker.sv
// memshare_arr_rqst_tracker: profiles share-group request patterns, classifies
// shared-column bank conflicts and queues them for the memShare allocator.
// Ports:
//   sys_clk, rstn            clock (rising edge), async active-low reset
//   rqst_valid/rqst_ready    upstream pattern handshake
//   rqst_vec, rqst_addr      request vector and per-requestor bank addresses
//   pat_valid/pat_ready      head-pattern handshake toward the allocator
//   pat_vec, pat_addr        head pattern as captured
//   pat_conflict             requestors deferred to allocation sequence 2
//   pat_seq_num              1 or 2 allocation sequences for the head pattern
//   occupancy, seq2_cnt      stored entries / stored entries needing 2 sequences
module memshare_arr_rqst_tracker #(
    parameter int                            SHARE_GROUP_SIZE   = 5,
    parameter logic [SHARE_GROUP_SIZE-1:0]   SHARE_COL_CONFIG   = 5'b10101,
    parameter int                            RQST_ADDR_BITWIDTH = 3,
    parameter int                            TRACK_DEPTH        = 4,
    parameter int                            CNT_W              = $clog2(TRACK_DEPTH + 1)
) (
    input  logic                                         sys_clk,
    input  logic                                         rstn,
    input  logic                                         rqst_valid,
    output logic                                         rqst_ready,
    input  logic [SHARE_GROUP_SIZE-1:0]                  rqst_vec,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr,
    output logic                                         pat_valid,
    input  logic                                         pat_ready,
    output logic [SHARE_GROUP_SIZE-1:0]                  pat_vec,
    output logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] pat_addr,
    output logic [SHARE_GROUP_SIZE-1:0]                  pat_conflict,
    output logic [1:0]                                   pat_seq_num,
    output logic [CNT_W-1:0]                             occupancy,
    output logic [CNT_W-1:0]                             seq2_cnt
);
    localparam int G  = SHARE_GROUP_SIZE;
    localparam int W  = RQST_ADDR_BITWIDTH;
    localparam int PW = $clog2(TRACK_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TRACK_DEPTH);

    logic [G-1:0]   vec_mem_q  [TRACK_DEPTH];
    logic [G*W-1:0] addr_mem_q [TRACK_DEPTH];
    logic [G-1:0]   conf_mem_q [TRACK_DEPTH];
    logic           seq2_mem_q [TRACK_DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d, seq2_cnt_q, seq2_cnt_d;
    logic [G-1:0]     conflict;
    logic             push, pop;

    // A requestor is deferred if any lower-index active shared requestor hits the
    // same bank; the lowest member of each colliding set stays in sequence 1.
    always_comb begin
        conflict = '0;
        for (int j = 1; j < G; j++)
            for (int i = 0; i < j; i++)
                if (rqst_vec[i] && rqst_vec[j] && SHARE_COL_CONFIG[i] && SHARE_COL_CONFIG[j] &&
                    rqst_addr[i*W +: W] == rqst_addr[j*W +: W])
                    conflict[j] = 1'b1;
    end

    assign rqst_ready = occ_q < DEPTH_C;
    assign pat_valid  = occ_q != '0;

    // Null patterns complete the handshake but are never stored.
    always_comb begin
        push       = rqst_valid && rqst_ready && (rqst_vec != '0);
        pop        = pat_valid && pat_ready;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);
        seq2_cnt_d = seq2_cnt_q + CNT_W'(push && conflict != '0) - CNT_W'(pop && seq2_mem_q[rd_ptr_q]);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            seq2_cnt_q <= '0;
            for (int k = 0; k < TRACK_DEPTH; k++) begin
                vec_mem_q[k]  <= '0;
                addr_mem_q[k] <= '0;
                conf_mem_q[k] <= '0;
                seq2_mem_q[k] <= 1'b0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            seq2_cnt_q <= seq2_cnt_d;
            if (push) begin
                vec_mem_q[wr_ptr_q]  <= rqst_vec;
                addr_mem_q[wr_ptr_q] <= rqst_addr;
                conf_mem_q[wr_ptr_q] <= conflict;
                seq2_mem_q[wr_ptr_q] <= conflict != '0;
            end
        end
    end

    assign pat_vec      = vec_mem_q[rd_ptr_q];
    assign pat_addr     = addr_mem_q[rd_ptr_q];
    assign pat_conflict = conf_mem_q[rd_ptr_q];
    assign pat_seq_num  = seq2_mem_q[rd_ptr_q] ? 2'd2 : 2'd1;
    assign occupancy    = occ_q;
    assign seq2_cnt     = seq2_cnt_q;
endmodule

// File: tb/tb_memshare_arr_rqst_tracker.sv
// tb_memshare_arr_rqst_tracker: directed plus randomized check against a queue model.
module tb_memshare_arr_rqst_tracker;
    localparam int G = 5;
    localparam int W = 3;
    localparam int D = 4;
    localparam int CW = 3;
    localparam logic [G-1:0] SH = 5'b10101;

    typedef struct packed {
        logic [G-1:0]   vec;
        logic [G*W-1:0] addr;
        logic [G-1:0]   conf;
    } ent_t;

    logic sys_clk = 1'b0;
    logic rstn = 1'b1;
    logic rqst_valid = 1'b0;
    logic pat_ready = 1'b0;
    logic [G-1:0] rqst_vec = '0;
    logic [G*W-1:0] rqst_addr = '0;
    logic rqst_ready, pat_valid;
    logic [G-1:0] pat_vec, pat_conflict;
    logic [G*W-1:0] pat_addr;
    logic [1:0] pat_seq_num;
    logic [CW-1:0] occupancy, seq2_cnt;

    ent_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    memshare_arr_rqst_tracker #(
        .SHARE_GROUP_SIZE(G), .SHARE_COL_CONFIG(SH), .RQST_ADDR_BITWIDTH(W), .TRACK_DEPTH(D), .CNT_W(CW)
    ) dut (
        .sys_clk(sys_clk), .rstn(rstn), .rqst_valid(rqst_valid), .rqst_ready(rqst_ready),
        .rqst_vec(rqst_vec), .rqst_addr(rqst_addr), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pat_vec(pat_vec), .pat_addr(pat_addr), .pat_conflict(pat_conflict),
        .pat_seq_num(pat_seq_num), .occupancy(occupancy), .seq2_cnt(seq2_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk requestors in index order; a shared requestor whose bank was already
    // claimed by an earlier shared requestor is deferred.
    function automatic logic [G-1:0] ref_conf(input logic [G-1:0] vec, input logic [G*W-1:0] addr);
        logic [(1<<W)-1:0] seen = '0;
        logic [G-1:0] c = '0;
        for (int i = 0; i < G; i++)
            if (vec[i] && SH[i]) begin
                if (seen[addr[i*W +: W]]) c[i] = 1'b1;
                else seen[addr[i*W +: W]] = 1'b1;
            end
        return c;
    endfunction

    function automatic int ref_seq2();
        int n = 0;
        foreach (q[k]) if (q[k].conf != '0) n++;
        return n;
    endfunction

    task automatic check_all();
        chk("rqst_ready", rqst_ready, q.size() < D);
        chk("pat_valid", pat_valid, q.size() != 0);
        chk("occupancy", occupancy, q.size());
        chk("seq2_cnt", seq2_cnt, ref_seq2());
        if (q.size() != 0) begin
            chk("pat_vec", pat_vec, q[0].vec);
            chk("pat_addr", pat_addr, q[0].addr);
            chk("pat_conflict", pat_conflict, q[0].conf);
            chk("pat_seq_num", pat_seq_num, (q[0].conf != '0) ? 2 : 1);
        end
    endtask

    task automatic chk_reset();
        chk("rst_pat_valid", pat_valid, 0);
        chk("rst_rqst_ready", rqst_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_seq2_cnt", seq2_cnt, 0);
        chk("rst_pat_vec", pat_vec, 0);
        chk("rst_pat_addr", pat_addr, 0);
        chk("rst_pat_conflict", pat_conflict, 0);
        chk("rst_pat_seq_num", pat_seq_num, 1);
    endtask

    task automatic step(input logic v, input logic [G-1:0] vec, input logic [G*W-1:0] addr, input logic pr);
        logic pu, po;
        ent_t e;
        rqst_valid = v;
        rqst_vec   = vec;
        rqst_addr  = addr;
        pat_ready  = pr;
        @(negedge sys_clk);
        check_all();
        @(posedge sys_clk);
        pu = v && (q.size() < D);
        po = pr && (q.size() != 0);
        if (po) void'(q.pop_front());
        if (pu && vec != '0) begin
            e.vec  = vec;
            e.addr = addr;
            e.conf = ref_conf(vec, addr);
            q.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < D + 1; k++) if (q.size() != 0) step(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1 chk_reset();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rstn = 1'b1;
        @(posedge sys_clk);
        #1;

        step(1'b1, 5'b00101, '0, 1'b0);
        chk("tp1_conflict", pat_conflict, 5'b00100);
        chk("tp1_seq_num", pat_seq_num, 2);
        chk("tp1_seq2_cnt", seq2_cnt, 1);
        drain();

        step(1'b1, 5'b11111, {5{3'd2}}, 1'b0);
        chk("tp2_conflict", pat_conflict, 5'b10100);
        step(1'b1, 5'b10101, {3'd1, 3'd0, 3'd2, 3'd0, 3'd0}, 1'b1);
        chk("tp2b_conflict", pat_conflict, 5'b00000);
        chk("tp2b_seq_num", pat_seq_num, 1);
        drain();

        for (int k = 0; k < D; k++) step(1'b1, G'(k + 1), G*W'($urandom), 1'b0);
        chk("full_occ", occupancy, 4);
        chk("full_ready", rqst_ready, 0);
        step(1'b1, 5'b11111, '0, 1'b0);
        chk("full_head_stable", pat_vec, 5'b00001);
        step(1'b1, 5'b11111, '0, 1'b1);
        chk("pop_from_full_occ", occupancy, 3);
        step(1'b1, 5'b11111, '0, 1'b0);
        chk("refill_occ", occupancy, 4);
        drain();

        step(1'b1, 5'b00101, '0, 1'b0);
        step(1'b1, 5'b00001, '0, 1'b0);
        step(1'b1, 5'b00101, '0, 1'b1);
        chk("swap_occ", occupancy, 2);
        chk("swap_seq2", seq2_cnt, 1);
        step(1'b1, 5'b00000, '0, 1'b0);
        chk("null_occ", occupancy, 2);
        drain();

        for (int k = 0; k < 400; k++) begin
            logic [G*W-1:0] a;
            for (int i = 0; i < G; i++) a[i*W +: W] = W'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? '0 : G'($urandom),
                 a,
                 $urandom_range(0, 99) < ((k % 100) < 50 ? 30 : 75));
        end
        drain();

        for (int k = 0; k < 3; k++) step(1'b1, 5'b00101, '0, 1'b0);
        chk("pre_rst_occ", occupancy, 3);
        #3 rstn = 1'b0;
        #1 chk_reset();
        q.delete();
        @(posedge sys_clk);
        #1 chk_reset();
        #2 rstn = 1'b1;
        step(1'b1, 5'b10001, {3'd4, 3'd0, 3'd0, 3'd0, 3'd4}, 1'b0);
        chk("post_rst_valid", pat_valid, 1);
        chk("post_rst_conflict", pat_conflict, 5'b10000);
        step(1'b0, '0, '0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/memshare_arr_rqst_tracker.md
# memshare_arr_rqst_tracker

Arrival-requestor profiling stage directly upstream of the SCU.memShare() allocator. Each accepted cycle it captures the share-group request vector and per-requestor column-bank addresses, and classifies shared-column bank conflicts. It queues the result in an ARR_RQST_TRACK_DEPTH-entry FIFO and presents one pattern at a time, with its required allocation-sequence count (1 or 2), to the allocator. A running count of queued 2-sequence patterns lets the scheduler anticipate READ_2SEQ pressure.

## Interface
- SHARE_GROUP_SIZE, 5, requestors per share group (GP1+GP2)
- SHARE_COL_CONFIG, 5'b10101, bit i = 1: requestor i targets a shared column
- RQST_ADDR_BITWIDTH, 3, column-bank address width per requestor
- TRACK_DEPTH, 4, FIFO entries (= ARR_RQST_TRACK_DEPTH); power of two, ≥2
- CNT_W, $clog2(TRACK_DEPTH+1), occupancy/counter width

Ports:
- sys_clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- rqst_valid  in  1  upstream pattern valid
- rqst_ready  out  1  tracker can accept
- rqst_vec  in  SHARE_GROUP_SIZE  bit i = requestor i active
- rqst_addr  in  SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  requestor i address at [i*W +: W]
- pat_valid  out  1  head pattern valid
- pat_ready  in  1  allocator consumes head
- pat_vec  out  SHARE_GROUP_SIZE  head request vector
- pat_addr  out  SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH  head addresses
- pat_conflict  out  SHARE_GROUP_SIZE  requestors deferred to sequence 2
- pat_seq_num  out  2  1 or 2 allocation sequences (MAX_ALLOC_SEQ_NUM = 2)
- occupancy  out  CNT_W  stored entries
- seq2_cnt  out  CNT_W  stored entries with pat_seq_num = 2

## Operation
- Push: rqst_valid & rqst_ready. Pop: pat_valid & pat_ready.
- rqst_ready = (occupancy < TRACK_DEPTH). There is no full bypass: a pop in the same cycle does not raise rqst_ready.
- Null pattern (rqst_vec == 0): accepted when rqst_ready = 1 but not stored. Occupancy and counters are unchanged.
- Conflict classification is combinational on the input and is stored with the entry:
  - Pair (i, j), i < j, conflicts iff rqst_vec[i] & rqst_vec[j] & SHARE_COL_CONFIG[i] & SHARE_COL_CONFIG[j] & (addr_i == addr_j).
  - conflict[j] = 1 if j conflicts with any lower i. The lowest-index member of each colliding set stays in sequence 1.
  - Non-shared requestors never conflict.
  - pat_seq_num = 2 if conflict != 0, else 1.
- FIFO:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(TRACK_DEPTH) bits, wrapping modulo TRACK_DEPTH.
  - Output fields are driven from entry[rd_ptr] and are registered storage.
  - pat_valid = (occupancy != 0).
- Counters:
  - occupancy = +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
  - seq2_cnt = +(pushed entry seq2) − (popped entry seq2), applied on the same edge.
  - Invariant: seq2_cnt ≤ occupancy.
- Reset (rstn low, asynchronous):
  - Pointers, occupancy and seq2_cnt are cleared; pat_valid = 0, so rqst_ready = 1.
  - pat_vec, pat_addr and pat_conflict read 0; pat_seq_num reads 1.
  - Entry storage is cleared.
  - A reset mid-operation discards all queued patterns with no output handshake.
- Outputs are stable while pat_valid = 1 and pat_ready = 0.

## Timing
- Push at edge N makes the pattern visible on pat_* and raises pat_valid after edge N (first cycle N+1) when the FIFO was empty. Latency is 1 cycle.
- Pop at edge N: the next entry is presented in cycle N+1; pat_valid falls after edge N if that was the last entry.
- A simultaneous push into an empty FIFO and pop is impossible, because pat_valid = 0.
- A simultaneous push and pop at occupancy 1 keeps pat_valid = 1, with the new entry presented in the next cycle.
- rqst_ready falls in the cycle after the push that reaches TRACK_DEPTH. It rises in the cycle after the first pop from full.
- occupancy and seq2_cnt update on the same edge as the handshake; they are registered outputs.

## Test plan
- Reset, then push vec=5'b00101 with addr0=0, addr2=0 (shared pair, same bank) -> next cycle pat_valid=1, pat_conflict=5'b00100, pat_seq_num=2, seq2_cnt=1.
- Push vec=5'b11111 with all addresses = 2 -> pat_conflict=5'b10100 (requestors 1 and 3 are non-shared, so exempt), pat_seq_num=2. Then push vec=5'b10101 with addresses 0, 2, 1 on requestors 0, 2, 4 -> pat_conflict=0, pat_seq_num=1.
- Hold pat_ready=0 and push 4 non-null patterns -> occupancy=4 and rqst_ready=0 from the next cycle. A 5th rqst_valid is not accepted; pat_* stay stable.
- From full, assert pat_ready for 1 cycle while rqst_valid=1 -> the pop occurs, no push that cycle, occupancy=3. The next cycle the push is accepted and occupancy=4. The FIFO order of 6+ patterns is preserved across pointer wrap.
- At occupancy=2 (one entry seq2), push a seq2 entry and pop the head seq2 entry simultaneously -> occupancy=2, seq2_cnt=1. Push vec=0 -> accepted, occupancy unchanged.
- Deassert rstn asynchronously mid-cycle with 3 entries queued -> pat_valid, occupancy and seq2_cnt go to 0 immediately and rqst_ready=1. After release, the first push reappears with 1-cycle latency.
